contador_updown_param: RTL
==========================

Name: contador_updown_param

Overview:
- Parametrised successor of the fixed-range setting counter used in the time/date adjust path.
- Up/down counter with programmable bounds, two preset loads, a direct parallel load, a programmable underflow value, and wrap or saturate mode.
- Adds carry/borrow pulses so that counters can be cascaded (e.g. minutes into hours).
- Adds an optional press-and-hold auto-repeat FSM so button-driven adjustment steps at a controlled rate.

Parameters:
- WIDTH, 7: counter width in bits.
- MIN_VAL, 0: lower bound.
- MAX_VAL, 93: upper bound.
- UNDER_VAL, 88: value loaded on a down-step from MIN_VAL in wrap mode.
- LD1_VAL, 53: preset loaded by Ld_1.
- LD2_VAL, 88: preset loaded by Ld_2.
- RST_VAL, 0: value after reset.
- SATURATE, 0: 0 = wrap at bounds, 1 = hold at bounds.
- STEP_MODE, 0: 0 = level (one step per enabled cycle while held), 1 = auto-repeat.
- REPEAT_DLY, 8: enabled ticks from first step to first repeat (STEP_MODE=1).
- REPEAT_RATE, 2: enabled ticks between repeats (STEP_MODE=1). Must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low. Sampled on the clk rising edge only.
- EN  in  1  tick enable. Nothing except reset advances while EN=0.
- up  in  1  count-up request.
- down  in  1  count-down request.
- Ld_1  in  1  load LD1_VAL.
- Ld_2  in  1  load LD2_VAL.
- ld  in  1  load ld_data.
- ld_data  in  WIDTH  parallel load value.
- out  out  WIDTH  counter value, registered.
- carry  out  1  one-cycle pulse on a wrap from MAX_VAL to MIN_VAL.
- borrow  out  1  one-cycle pulse on a wrap from MIN_VAL to UNDER_VAL.
- at_max  out  1  out >= MAX_VAL, registered.
- at_min  out  1  out <= MIN_VAL, registered.

Behaviour:
Reset (rst=0 at a clk edge):
- out = RST_VAL, carry = 0, borrow = 0.
- at_max and at_min reflect RST_VAL.
- Repeat FSM goes to IDLE and its tick counter clears.
- Reset wins over every other input, including mid-repeat.

When EN=0:
- out and the FSM hold.
- carry and borrow are 0.

When EN=1, one action is taken, in this priority order:
1. Ld_1 xor Ld_2: load the matching preset.
   - Ld_1=Ld_2=1 counts as no preset load and falls through.
2. ld=1: out = ld_data clamped to [MIN_VAL, MAX_VAL].
3. Step, only when up xor down and the step is qualified by STEP_MODE.
   - up=down=1 means no step.

Up-step:
- out < MAX_VAL: out + 1.
- out >= MAX_VAL with SATURATE=0: out = MIN_VAL, carry = 1.
- out >= MAX_VAL with SATURATE=1: hold, no carry.

Down-step:
- out > MIN_VAL: out - 1.
- out <= MIN_VAL with SATURATE=0: out = UNDER_VAL, borrow = 1.
- out <= MIN_VAL with SATURATE=1: hold, no borrow.

Loads and FSM:
- Any load asserts neither carry nor borrow.
- Any load returns the FSM to IDLE.

Arithmetic:
- WIDTH-bit unsigned arithmetic.
- Comparisons are unsigned, so out-of-range values left by legal parameters are still handled.

Step qualification:
- STEP_MODE=0: a step happens every EN cycle while the request is held (legacy behaviour).
- STEP_MODE=1 uses an FSM with states IDLE, DELAY, REPEAT. The state and tick counter advance only on EN=1.
  - IDLE: on a valid request, step immediately, clear the counter, go to DELAY.
  - DELAY: count enabled ticks. When REPEAT_DLY is reached, step, clear the counter, go to REPEAT.
  - REPEAT: step every REPEAT_RATE enabled ticks.
  - Request dropped (up=down=0, up=down=1, or the direction changed): go to IDLE with no step that cycle.
  - A direction change takes effect on the next enabled cycle as a fresh press.

Latency and legal parameters:
- All outputs update on the clk edge that samples the qualifying inputs; one-cycle latency.
- Required: MIN_VAL <= LD1_VAL, LD2_VAL, UNDER_VAL, RST_VAL <= MAX_VAL < 2^WIDTH.

Optional Feature:
Macro CONTADOR_BCD_OUT_EN.
- Defined:
  - Adds outputs bcd_tens[3:0] and bcd_units[3:0], registered from the next value of out, so they are aligned with out in the same cycle.
  - Reset value is the BCD of RST_VAL.
  - MAX_VAL <= 99 is required in this build.
- Undefined:
  - The ports do not exist and no divider logic is built.

Test Plan:
1. rst=0 for 2 cycles with defaults -> out=0, at_min=1, carry=0, borrow=0. Then EN=1, Ld_1=1 -> out=53 next cycle. Ld_1=Ld_2=1 with up=1 -> out=54.
2. Defaults, out=92, EN=1, up=1 held for 3 cycles -> 93, 0, 1. carry=1 only in the cycle out becomes 0. Then down=1 from 0 -> out=88 with borrow=1.
3. SATURATE=1, MIN_VAL=1, MAX_VAL=12, out=12, up=1 for 4 cycles -> out stays 12, carry never asserts. ld=1, ld_data=127 -> out=12. ld_data=0 -> out=1.
4. STEP_MODE=1, REPEAT_DLY=8, REPEAT_RATE=2, out=10, EN=1, up held 20 cycles -> steps at cycles 0, 8, 10, 12, 14, 16, 18, giving out=17. Release for 1 cycle and press again -> immediate step to 18.
5. STEP_MODE=1 with up held and EN toggling every other cycle -> step spacing doubles in clk cycles. rst=0 in REPEAT -> out=RST_VAL, FSM IDLE, the next press steps immediately.
6. CONTADOR_BCD_OUT_EN defined, MAX_VAL=59, load ld_data=47 -> bcd_tens=4, bcd_units=7 in the same cycle as out=47. Up from 59 -> 0/0 together with carry=1.

Source files
------------

// File: rtl/contador_updown_param.sv
// Parametrised up/down setting counter: bounds, presets, clamped load, wrap/saturate,
// cascade carry/borrow, optional auto-repeat stepping. Macro CONTADOR_BCD_OUT_EN adds BCD outputs.
//
// state    | meaning
// S_IDLE   | no request held; a valid request steps at once
// S_DELAY  | first step done, counting down to the first repeat
// S_REPEAT | repeating every REPEAT_RATE enabled ticks
module contador_updown_param #(
  parameter int WIDTH       = 7,
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 93,
  parameter int UNDER_VAL   = 88,
  parameter int LD1_VAL     = 53,
  parameter int LD2_VAL     = 88,
  parameter int RST_VAL     = 0,
  parameter int SATURATE    = 0,
  parameter int STEP_MODE   = 0,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             up,
  input  logic             down,
  input  logic             Ld_1,
  input  logic             Ld_2,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_min
`ifdef CONTADOR_BCD_OUT_EN
  ,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units
`endif
);

  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] UNDER_W = WIDTH'(UNDER_VAL);
  localparam logic [WIDTH-1:0] LD1_W   = WIDTH'(LD1_VAL);
  localparam logic [WIDTH-1:0] LD2_W   = WIDTH'(LD2_VAL);
  localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RST_VAL);

  // Tick timer is a down-counter: loaded with N-1, a step fires when it reads zero.
  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_LD  = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] RATE_LD = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             at_max_q, at_min_q;
  logic             req;
  logic             step;

  assign req = up ^ down;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    dir_d    = dir_q;
    out_d    = out_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    step     = 1'b0;
    if (EN) begin
      if (Ld_1 ^ Ld_2) begin
        out_d   = Ld_1 ? LD1_W : LD2_W;
        state_d = S_IDLE;
      end else if (ld) begin
        if (ld_data <= MIN_W)      out_d = MIN_W;
        else if (ld_data >= MAX_W) out_d = MAX_W;
        else                       out_d = ld_data;
        state_d = S_IDLE;
      end else begin
        if (STEP_MODE == 0) begin
          step = req;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (req) begin
                step    = 1'b1;
                dir_d   = up;
                tick_d  = DLY_LD;
                state_d = S_DELAY;
              end
            end
            S_DELAY, S_REPEAT: begin
              // Dropped request or reversed direction: restart as a fresh press next tick.
              if (!req || (up != dir_q)) begin
                state_d = S_IDLE;
              end else if (tick_q == '0) begin
                step    = 1'b1;
                tick_d  = RATE_LD;
                state_d = S_REPEAT;
              end else begin
                tick_d = tick_q - CNT_W'(1);
              end
            end
            default: state_d = S_IDLE;
          endcase
        end

        if (step) begin
          if (up) begin
            if (out_q < MAX_W) begin
              out_d = out_q + WIDTH'(1);
            end else if (SATURATE == 0) begin
              out_d   = MIN_W;
              carry_d = 1'b1;
            end
          end else begin
            if (out_q > MIN_W) begin
              out_d = out_q - WIDTH'(1);
            end else if (SATURATE == 0) begin
              out_d    = UNDER_W;
              borrow_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      dir_q    <= 1'b0;
      out_q    <= RST_W;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      at_max_q <= (RST_W >= MAX_W);
      at_min_q <= (RST_W <= MIN_W);
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      dir_q    <= dir_d;
      out_q    <= out_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      at_max_q <= (out_d >= MAX_W);
      at_min_q <= (out_d <= MIN_W);
    end
  end

  assign out    = out_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;

`ifdef CONTADOR_BCD_OUT_EN
  logic [3:0] bcd_tens_q, bcd_units_q;

  // Converted from the next value so the digits line up with out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd_tens_q  <= 4'(RST_VAL / 10);
      bcd_units_q <= 4'(RST_VAL % 10);
    end else begin
      bcd_tens_q  <= 4'(out_d / WIDTH'(10));
      bcd_units_q <= 4'(out_d % WIDTH'(10));
    end
  end

  assign bcd_tens  = bcd_tens_q;
  assign bcd_units = bcd_units_q;
`endif

endmodule
